// File: rtl/cla_seq_adder_if.sv
// -----------------------------------------------------------------------------
// cla_seq_adder_if
// Start/done handshake and operand/result bus between the ALU control FSM
// (master) and the sequential carry look-ahead adder (slave).
//
// Signals:
//   start   master->slave  request, sampled only while ready=1
//   op_sub  master->slave  0: A+B, 1: A-B, sampled with start
//   A, B    master->slave  WIDTH-bit operands, sampled with start
//   ready   slave->master  adder idle, start will be accepted
//   busy    slave->master  operation in progress (RUN or DONE)
//   done    slave->master  one-cycle pulse, S/COUT valid
//   S       slave->master  WIDTH-bit result
//   COUT    slave->master  carry out of bit WIDTH-1 (sub: 1 = no borrow)
//   zero    slave->master  S == 0           (only with CLA_SEQ_FLAGS_EN)
//   ovf     slave->master  signed overflow  (only with CLA_SEQ_FLAGS_EN)
//
// Optional macro: CLA_SEQ_FLAGS_EN adds the zero/ovf flag signals.
// -----------------------------------------------------------------------------
interface cla_seq_adder_if #(
  parameter int WIDTH = 64
);
  logic             start;
  logic             op_sub;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             COUT;
`ifdef CLA_SEQ_FLAGS_EN
  logic             zero;
  logic             ovf;
`endif

`ifdef CLA_SEQ_FLAGS_EN
  modport master (
    output start, op_sub, A, B,
    input  ready, busy, done, S, COUT, zero, ovf
  );

  modport slave (
    input  start, op_sub, A, B,
    output ready, busy, done, S, COUT, zero, ovf
  );
`else
  modport master (
    output start, op_sub, A, B,
    input  ready, busy, done, S, COUT
  );

  modport slave (
    input  start, op_sub, A, B,
    output ready, busy, done, S, COUT
  );
`endif

endinterface

// File: rtl/cla_seq_adder.sv
// -----------------------------------------------------------------------------
// cla_seq_adder
// Multi-cycle add/subtract unit. One 8-bit carry look-ahead slice is reused
// NB = WIDTH/8 times, least significant byte first, so a WIDTH-bit add costs
// one byte-wide adder plus operand/result registers instead of a full-width
// adder. Intended for non-critical ALU paths (address/counter updates).
//
// Sequence: IDLE -(start)-> RUN (NB cycles) -> DONE (done=1) -> IDLE.
// start accepted at edge E0, done high in the cycle after edge E_NB,
// ready back at edge E_NB+1.
//
// Parameters:
//   WIDTH  operand width, multiple of 8 and >= 16
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high; aborts any operation without done
//   bus    cla_seq_adder_if.slave (start/op_sub/A/B in; ready/busy/done/S/COUT out)
//
// Optional macro: CLA_SEQ_FLAGS_EN adds registered zero and signed-overflow
// flags, updated at the same edge as COUT and held with S.
// -----------------------------------------------------------------------------
module cla_seq_adder #(
  parameter int WIDTH = 64
) (
  input  logic          clk,
  input  logic          reset,
  cla_seq_adder_if.slave bus
);

  localparam int                NB       = WIDTH / 8;
  localparam int                IDX_W    = $clog2(NB);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NB - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;   // B already inverted for subtract
  logic [WIDTH-1:0] r_s;
  logic [IDX_W-1:0] r_idx;
  logic             r_carry;
  logic             r_cout;

  logic             w_ready;
  logic             w_busy;
  logic             w_done;
  logic             w_accept;
  logic             w_last;

  logic [7:0]       w_slice_a;
  logic [7:0]       w_slice_b;
  logic [7:0]       w_sum;
  logic             w_slice_cout;
  logic [7:0]       w_g;
  logic [7:0]       w_p;
  logic [8:0]       w_c;

  // ---------------------------------------------------------------------------
  // Byte slice operand select
  // ---------------------------------------------------------------------------
  assign w_slice_a = r_opa[{r_idx, 3'b000} +: 8];
  assign w_slice_b = r_opb[{r_idx, 3'b000} +: 8];
  assign w_last    = (r_idx == LAST_IDX);

  // ---------------------------------------------------------------------------
  // 8-bit carry look-ahead slice (cla_adder8b).
  // Each carry is the flat sum-of-products
  //   c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin
  // rather than a ripple chain; gc packs {g, cin} so term j starts at gc[j].
  // ---------------------------------------------------------------------------
  always_comb begin : cla_adder8b
    logic [8:0] gc;
    logic       acc;
    logic       term;
    // NOTE: every variable assigned in a combinational block gets a default
    // first, so no path can leave it unassigned and infer a latch.
    w_g    = w_slice_a & w_slice_b;
    w_p    = w_slice_a ^ w_slice_b;
    gc     = {w_g, r_carry};
    w_c    = '0;
    w_c[0] = r_carry;
    for (int i = 0; i < 8; i++) begin
      acc = 1'b0;
      for (int j = 0; j <= i + 1; j++) begin
        term = gc[j];
        for (int k = j; k <= i; k++) begin
          term = term & w_p[k];
        end
        acc = acc | term;
      end
      w_c[i+1] = acc;
    end
  end

  assign w_sum        = w_p ^ w_c[7:0];
  assign w_slice_cout = w_c[8];

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ready = 1'b1;
        if (bus.start) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_busy = 1'b1;
        if (w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_busy      = 1'b1;
        w_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: operand capture, byte-serial accumulation, final carry
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: operand and result registers are plain flops (not a RAM), so they
      // are reset explicitly; an abort must leave S/COUT at a defined zero.
      r_opa   <= '0;
      r_opb   <= '0;
      r_s     <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_opa   <= bus.A;
      r_opb   <= bus.op_sub ? ~bus.B : bus.B;
      r_carry <= bus.op_sub;   // +1 of the two's complement enters as carry-in
      r_idx   <= '0;
    end else if (r_state == ST_RUN) begin
      r_s[{r_idx, 3'b000} +: 8] <= w_sum;
      r_carry                   <= w_slice_cout;
      if (w_last) r_cout <= w_slice_cout;
      else        r_idx  <= r_idx + IDX_W'(1);
    end
  end

`ifdef CLA_SEQ_FLAGS_EN
  logic r_zero;
  logic r_ovf;
  logic w_zero_nxt;
  logic w_ovf_nxt;

  // At the last step the top byte is still in flight; the lower bytes are
  // already in r_s, so the complete result is {w_sum, r_s[WIDTH-9:0]}.
  assign w_zero_nxt = ({w_sum, r_s[WIDTH-9:0]} == '0);
  assign w_ovf_nxt  = (r_opa[WIDTH-1] == r_opb[WIDTH-1]) &&
                      (w_sum[7] != r_opa[WIDTH-1]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_zero <= 1'b0;
      r_ovf  <= 1'b0;
    end else if ((r_state == ST_RUN) && w_last) begin
      r_zero <= w_zero_nxt;
      r_ovf  <= w_ovf_nxt;
    end
  end

  assign bus.zero = r_zero;
  assign bus.ovf  = r_ovf;
`endif

  assign bus.ready = w_ready;
  assign bus.busy  = w_busy;
  assign bus.done  = w_done;
  assign bus.S     = r_s;
  assign bus.COUT  = r_cout;

endmodule

// File: doc/cla_seq_adder.md
Name: cla_seq_adder

Overview:
- Multi-cycle add/subtract sequencer that time-shares one 8-bit carry look-ahead slice (cla_adder8b) to add or subtract WIDTH-bit operands, one byte per clock, least significant byte first.
- Area-reduced alternative to a full-width adder for the non-critical ALU path, e.g. address or counter updates.
- Start/done handshake toward the ALU control FSM.

Parameters:
WIDTH, 64, operand width in bits; must be a multiple of 8 and at least 16; NB = WIDTH/8 byte steps.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled only when ready=1
op_sub  input  1  0: A+B, 1: A-B (two's complement); sampled with start
A  input  WIDTH  operand A; sampled with start
B  input  WIDTH  operand B; sampled with start
ready  output  1  high in IDLE; start is accepted
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse; S and COUT valid
S  output  WIDTH  result register
COUT  output  1  carry out of bit WIDTH-1 (for sub: 1 = no borrow)

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - state=IDLE, byte index=0, carry reg=0, operand regs=0.
  - S=0, COUT=0, done=0, busy=0, ready=1.
  - A partial result is discarded; no done is issued for the aborted operation.
- State machine: IDLE -> RUN -> DONE -> IDLE.
- IDLE: on a clock edge with start=1:
  - latch A into opa.
  - latch opb = op_sub ? ~B : B.
  - carry reg = op_sub.
  - index = 0; next state RUN.
  - start=0: remain in IDLE.
- RUN:
  - Slice inputs: opa byte[index], opb byte[index], carry reg.
  - Each edge: S byte[index] <= slice sum; carry reg <= slice COUT; index <= index+1.
  - At the edge where index = NB-1: COUT <= slice COUT; next state DONE.
- DONE: done=1 for exactly one cycle; next state IDLE unconditionally.
- Latency: start accepted at edge E0; done high during the cycle following edge E_NB (8 edges later for WIDTH=64); ready returns at edge E_NB+1.
- Result holding:
  - S and COUT hold their values from the end of DONE until the next accepted start.
  - S bytes update progressively during RUN; S is only defined as valid while done=1 and afterwards.
- start while busy=1 (RUN or DONE) is ignored: no queuing, no effect on the current operation.
- start held high continuously: a new operation is accepted in each IDLE cycle, so back-to-back throughput is one op per NB+2 cycles.
- A, B and op_sub changes after the accepting edge have no effect.
- Index counter width: clog2(NB). It never wraps in normal operation; it is reset to 0 on every accept.
- Arithmetic:
  - S = (A + B + 0) mod 2^WIDTH, or (A + ~B + 1) mod 2^WIDTH.
  - COUT is the true carry out of the full-width operation.

Optional Feature:
- Macro: CLA_SEQ_FLAGS_EN.
- Defined: adds two outputs, both registered at the same edge as COUT and held with S.
  - zero (1 bit): S == 0.
  - ovf (1 bit): signed overflow = (opa[W-1] == opb[W-1]) && (S[W-1] != opa[W-1]), using the inverted B for subtract.
  - Both reset to 0.
- Not defined: ports absent and no flag logic is generated; all other behaviour is identical.

Test Plan:
- WIDTH=64, op_sub=0, A=0x00000000FFFFFFFF, B=0x1 -> done pulse 8 edges after accept; S=0x0000000100000000, COUT=0, busy high 9 cycles, ready low meanwhile.
- op_sub=0, A=0xFFFFFFFFFFFFFFFF, B=0x1 -> S=0x0, COUT=1; with CLA_SEQ_FLAGS_EN: zero=1, ovf=0.
- op_sub=1, A=0x5, B=0x7 -> S=0xFFFFFFFFFFFFFFFE, COUT=0; then op_sub=1, A=0x7, B=0x5 -> S=0x2, COUT=1.
- With CLA_SEQ_FLAGS_EN: op_sub=0, A=0x7FFFFFFFFFFFFFFF, B=0x1 -> S=0x8000000000000000, ovf=1, zero=0, COUT=0.
- Accept A=0x10, B=0x20; pulse start with A=0xFF, B=0xFF at RUN cycles 3 and DONE -> both ignored; S=0x30, exactly one done pulse, next start accepted only after ready=1.
- Assert reset asynchronously at RUN index 4 of A=0x0101010101010101+B=0x0101010101010101 -> outputs immediately S=0, COUT=0, busy=0, ready=1, no done; after reset a fresh op completes correctly with S=0x0202020202020202.
